// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  // Memory-wait tracking states
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_e;

  // Register r0 is hardwired zero and never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 64;

  // True when source a depends on an in-flight write to destination d
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] d, input logic en);
    return en && (d != REG_ZERO) && (a == d);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter used for performance statistics
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Count qualifying cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze scheduler for the 5-stage pipeline
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_single_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hazard_detected,
  output logic             freeze_if,
  output logic             freeze_all,
  output logic             flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT-1, the last wait index before giving up
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;

  logic w_use2;
  logic w_exe_hit;
  logic w_mem_hit;
  logic w_raw;
  logic w_mem_busy;

  assign w_use2    = !id_single_src;
  assign w_exe_hit = reg_match(id_src1, exe_dest, 1'b1) | (w_use2 & reg_match(id_src2, exe_dest, 1'b1));
  assign w_mem_hit = reg_match(id_src1, mem_dest, 1'b1) | (w_use2 & reg_match(id_src2, mem_dest, 1'b1));

  // With forwarding only a load in EXE cannot be bypassed in time
  assign w_raw = fwd_en ? (w_exe_hit & exe_wb_en & exe_mem_r_en)
                        : ((w_exe_hit & exe_wb_en) | (w_mem_hit & mem_wb_en));

  // Once timed out the memory is ignored so the pipeline can drain
  assign mem_err    = (r_state == ERR);
  assign w_mem_busy = rst & mem_req & !mem_ready & !mem_err;

  // Prioritised control: memory freeze, then branch flush, then RAW bubble
  always_comb begin
    hazard_detected = 1'b0;
    freeze_if       = 1'b0;
    freeze_all      = 1'b0;
    flush           = 1'b0;
    if (rst) begin
      if (w_mem_busy) begin
        freeze_all = 1'b1;
        freeze_if  = 1'b1;
      end else if (br_taken) begin
        flush = 1'b1;
      end else if (w_raw) begin
        hazard_detected = 1'b1;
        freeze_if       = 1'b1;
      end
    end
  end

  // Memory-wait state and consecutive-wait index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Next-state: enter WAIT on a stalled access, give up after MEM_TIMEOUT stalled cycles
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          w_state_nxt = WAIT;
          w_wait_nxt  = WAIT_ONE;
        end
      end
      WAIT: begin
        if (!mem_req || mem_ready) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = ERR;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + WAIT_ONE;
        end
      end
      ERR: begin
        w_state_nxt = ERR;
        w_wait_nxt  = '0;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (hazard_detected),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (freeze_all),
    .o_cnt (mem_wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (flush),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_single_src;
  logic [4:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [4:0] mem_dest;
  logic       mem_wb_en;
  logic       br_taken;
  logic       mem_req;
  logic       mem_ready;

  logic        a_hz, a_fi, a_fa, a_fl, a_err;
  logic [15:0] a_stall, a_mwait, a_flush;
  logic        b_hz, b_fi, b_fa, b_fl, b_err;
  logic [3:0]  b_stall, b_mwait, b_flush;

  int n_tests = 0;
  int n_fail  = 0;

  // model state per instance: 0 = default build, 1 = CNT_W=4/MEM_TIMEOUT=4 build
  int tmo[2]  = '{64, 4};
  int cmax[2] = '{65535, 15};
  int m_wcnt[2];
  bit m_err[2];
  int m_stall[2];
  int m_mwait[2];
  int m_flush[2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
    .id_single_src(id_single_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard_detected(a_hz), .freeze_if(a_fi), .freeze_all(a_fa), .flush(a_fl),
    .mem_err(a_err), .stall_cnt(a_stall), .mem_wait_cnt(a_mwait), .flush_cnt(a_flush)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
    .id_single_src(id_single_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard_detected(b_hz), .freeze_if(b_fi), .freeze_all(b_fa), .flush(b_fl),
    .mem_err(b_err), .stall_cnt(b_stall), .mem_wait_cnt(b_mwait), .flush_cnt(b_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit dep(input logic [4:0] a, input logic [4:0] d);
    return (d != 5'd0) && (a == d);
  endfunction

  // expected control outputs for instance k: {hazard, freeze_if, freeze_all, flush}
  function automatic logic [3:0] model_ctrl(input int k);
    bit exe_src, mem_src, raw, busy;
    exe_src = dep(id_src1, exe_dest) || (!id_single_src && dep(id_src2, exe_dest));
    mem_src = dep(id_src1, mem_dest) || (!id_single_src && dep(id_src2, mem_dest));
    if (fwd_en) raw = exe_src && exe_wb_en && exe_mem_r_en;
    else        raw = (exe_src && exe_wb_en) || (mem_src && mem_wb_en);
    busy = rst && mem_req && !mem_ready && !m_err[k];
    if (!rst)          return 4'b0000;
    else if (busy)     return 4'b0110;
    else if (br_taken) return 4'b0001;
    else if (raw)      return 4'b1100;
    else               return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wcnt[k] = 0; m_err[k] = 0; m_stall[k] = 0; m_mwait[k] = 0; m_flush[k] = 0;
    end
  endtask

  // inputs are applied; let them settle and compare both instances against the model
  task automatic settle_check();
    logic [3:0] ea, eb;
    #1;
    if (!rst) model_reset();
    ea = model_ctrl(0);
    eb = model_ctrl(1);
    chk("a_hazard", a_hz, ea[3]);   chk("a_freeze_if", a_fi, ea[2]);
    chk("a_freeze_all", a_fa, ea[1]); chk("a_flush", a_fl, ea[0]);
    chk("a_mem_err", a_err, m_err[0]);
    chk("a_stall_cnt", a_stall, m_stall[0]);
    chk("a_mem_wait_cnt", a_mwait, m_mwait[0]);
    chk("a_flush_cnt", a_flush, m_flush[0]);
    chk("b_hazard", b_hz, eb[3]);   chk("b_freeze_if", b_fi, eb[2]);
    chk("b_freeze_all", b_fa, eb[1]); chk("b_flush", b_fl, eb[0]);
    chk("b_mem_err", b_err, m_err[1]);
    chk("b_stall_cnt", b_stall, m_stall[1]);
    chk("b_mem_wait_cnt", b_mwait, m_mwait[1]);
    chk("b_flush_cnt", b_flush, m_flush[1]);
  endtask

  // advance one clock, updating the model with the values seen at the edge
  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        e = model_ctrl(k);
        if (e[3] && m_stall[k] < cmax[k]) m_stall[k]++;
        if (e[1] && m_mwait[k] < cmax[k]) m_mwait[k]++;
        if (e[0] && m_flush[k] < cmax[k]) m_flush[k]++;
        if (e[1]) begin
          m_wcnt[k]++;
          if (m_wcnt[k] >= tmo[k]) begin
            m_err[k]  = 1;
            m_wcnt[k] = 0;
          end
        end else begin
          m_wcnt[k] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fwd_en = 0; id_src1 = 0; id_src2 = 0; id_single_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
    br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    settle_check();
    tick();
    rst = 1;
    settle_check();
    tick();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    do_reset();
    chk("reset_stall_cnt", a_stall, 0);

    // RAW on EXE without forwarding
    idle_inputs(); id_src1 = 5; exe_dest = 5; exe_wb_en = 1;
    settle_check(); chk("tp_exe_raw", a_hz, 1); tick();
    chk("tp_stall_inc", a_stall, 1);
    exe_dest = 0; settle_check(); chk("tp_r0_no_raw", a_hz, 0); tick();

    // load-use with forwarding on src2
    idle_inputs(); fwd_en = 1; id_src2 = 7; exe_dest = 7; exe_wb_en = 1; exe_mem_r_en = 1;
    settle_check(); chk("tp_load_use", a_hz, 1); tick();
    id_single_src = 1; settle_check(); chk("tp_single_src", a_hz, 0); tick();
    id_single_src = 0; exe_mem_r_en = 0; settle_check(); chk("tp_fwd_no_load", a_hz, 0); tick();

    // branch beats hazard
    do_reset();
    idle_inputs(); id_src1 = 3; exe_dest = 3; exe_wb_en = 1; br_taken = 1;
    settle_check(); chk("tp_br_flush", a_fl, 1); chk("tp_br_no_fi", a_fi, 0); tick();
    chk("tp_flush_cnt", a_flush, 1);

    // three-cycle memory wait
    idle_inputs(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      br_taken = 1; settle_check(); tick();
    end
    mem_ready = 1; br_taken = 0; settle_check(); chk("tp_wait_done", a_fa, 0); tick();
    chk("tp_mem_wait_cnt", a_mwait, 3);
    idle_inputs(); settle_check(); tick();

    // timeout on both builds, then asynchronous reset mid-wait
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 66; i++) begin
      settle_check(); tick();
    end
    settle_check(); chk("tp_timeout_err", a_err, 1); chk("tp_timeout_unfrozen", a_fa, 0);
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 10; i++) begin
      settle_check(); tick();
    end
    #2 rst = 0;
    settle_check(); chk("tp_async_mwait", a_mwait, 0);
    tick();
    do_reset();

    // saturation on the 4-bit build
    idle_inputs(); id_src1 = 9; exe_dest = 9; exe_wb_en = 1;
    for (int i = 0; i < 20; i++) begin
      settle_check(); tick();
    end
    settle_check(); chk("tp_sat_stall", b_stall, 15);
    tick();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) != 0);
      fwd_en        = 1'($urandom_range(0, 1));
      id_src1       = 5'($urandom_range(0, 3));
      id_src2       = 5'($urandom_range(0, 3));
      id_single_src = 1'($urandom_range(0, 1));
      exe_dest      = 5'($urandom_range(0, 3));
      exe_wb_en     = 1'($urandom_range(0, 1));
      exe_mem_r_en  = 1'($urandom_range(0, 1));
      mem_dest      = 5'($urandom_range(0, 3));
      mem_wb_en     = 1'($urandom_range(0, 1));
      br_taken      = ($urandom_range(0, 4) == 0);
      mem_req       = ($urandom_range(0, 2) == 0);
      mem_ready     = ($urandom_range(0, 3) == 0);
      settle_check();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Decides each cycle whether the ID stage injects a bubble (drives ID hazard_detected), whether IF and the IF/ID register hold, whether the whole pipeline freezes for a multi-cycle data-memory access, and whether IF/ID is flushed on a taken branch.
- Tracks memory-wait state with an FSM, enforces a memory timeout, and keeps stall/flush performance counters.

Parameters:
CNT_W, 16, width of performance counters
MEM_TIMEOUT, 64, max consecutive wait cycles before mem_err (must be >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
fwd_en  in  1  1 = forwarding unit active, only load-use stalls
id_src1  in  5  ID source register 1
id_src2  in  5  ID source register 2
id_single_src  in  1  ID instruction reads src1 only
exe_dest  in  5  EXE-stage destination
exe_wb_en  in  1  EXE-stage writes back
exe_mem_r_en  in  1  EXE-stage is a load
mem_dest  in  5  MEM-stage destination
mem_wb_en  in  1  MEM-stage writes back
br_taken  in  1  branch resolved taken in EXE
mem_req  in  1  MEM stage performing load/store this cycle
mem_ready  in  1  data memory completes access this cycle
hazard_detected  out  1  to ID: zero control word (bubble)
freeze_if  out  1  hold PC and IF/ID register
freeze_all  out  1  hold every pipeline register
flush  out  1  clear IF/ID register
mem_err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with hazard_detected=1
mem_wait_cnt  out  CNT_W  cycles with freeze_all=1
flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- Reset (rst=0, async): state=RUN, all counters 0, mem_err=0. All combinational outputs forced 0 while rst=0.
- Match rules:
  - match(a,d,en) = en & (d!=0) & (a==d).
  - use2 = !id_single_src.
  - src hit at stage X = match(id_src1,X) | (use2 & match(id_src2,X)).
- raw_hazard:
  - fwd_en=0: EXE hit with exe_wb_en, or MEM hit with mem_wb_en.
  - fwd_en=1: EXE hit gated by exe_mem_r_en & exe_wb_en only (load-use).
- mem_busy = mem_req & !mem_ready & !mem_err.
- Priority, combinational, same cycle:
  - freeze_all = mem_busy.
  - If freeze_all=1: hazard_detected=0, flush=0, freeze_if=1. A pending branch is not lost; EXE is frozen and br_taken is re-evaluated next cycle.
  - Else if br_taken: flush=1, hazard_detected=0, freeze_if=0 (branch wins over hazard; the ID instruction is discarded).
  - Else if raw_hazard: hazard_detected=1, freeze_if=1.
  - Else: all 0.
- FSM (registered):
  - RUN: mem_busy -> WAIT with wait counter w=1.
  - WAIT: mem_ready -> RUN, w=0. Else w++. If w reaches MEM_TIMEOUT-1 and next cycle is still not ready -> ERR.
  - ERR: mem_err=1. mem_busy is forced 0 so the pipeline proceeds; stays in ERR until reset.
  - A mem_req dropping while in WAIT returns to RUN.
- Counters:
  - Each increments on its qualifying cycle and saturates at all-ones (no wrap).
  - Counters do not count while rst=0.
- Single-cycle access: mem_req & mem_ready in the same cycle gives no freeze and no WAIT entry.
- Latency: all control outputs are combinational from the current inputs (0-cycle). Only the FSM, mem_err and counters are registered (1 cycle).

Decomposition:
- Shared package hazard_pkg:
  - enum {RUN, WAIT, ERR} for the FSM state.
  - REG_ZERO=5'd0.
  - Default CNT_W and MEM_TIMEOUT constants.
- One natural sub-module: sat_counter (CNT_W-wide, enable input, saturating), instantiated three times.

Test Plan:
- fwd_en=0, id_src1=5, exe_dest=5, exe_wb_en=1 -> hazard_detected=1, freeze_if=1, stall_cnt increments by 1. Repeat with exe_dest=0 -> no hazard.
- fwd_en=1, id_src2=7, id_single_src=0, exe_dest=7, exe_mem_r_en=1 -> hazard=1. Same with id_single_src=1 -> hazard=0. Same with exe_mem_r_en=0 -> hazard=0.
- br_taken=1 together with a raw hazard -> flush=1, hazard_detected=0, freeze_if=0, flush_cnt=1.
- mem_req=1, mem_ready low for 3 cycles then high -> freeze_all=1 for exactly 3 cycles, hazard/flush masked, FSM RUN->WAIT->RUN, mem_wait_cnt=3.
- mem_req=1, mem_ready=0 held for MEM_TIMEOUT+2 cycles -> mem_err rises after MEM_TIMEOUT waits, freeze_all drops, mem_err stays 1. Drop rst to 0 mid-wait -> state RUN, counters 0, mem_err 0 immediately.
- Force stall_cnt near all-ones (small CNT_W=4 build) and keep hazard asserted 20 cycles -> stall_cnt holds 15, no wrap.
